// File: rtl/serial_mod_pkg.sv
// ============================================================================
// serial_mod_pkg: shared types, parameter limits and the single-bit remainder
// step used by serial_mod_checker.            Revision: 1.0
// ============================================================================
`default_nettype none

package serial_mod_pkg;

  localparam int DIVISOR_MIN   = 2;
  localparam int DIVISOR_MAX   = 256;
  localparam int FRAME_LEN_MIN = 0;
  localparam int FRAME_LEN_MAX = 65535;

  // Widest remainder needed at DIVISOR_MAX; the step works one bit wider.
  localparam int MAX_RW = 8;
  localparam int STEP_W = MAX_RW + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // r < divisor guarantees 2r+x < 2*divisor, so one conditional subtract suffices.
  function automatic logic [STEP_W-1:0] mod_step(input logic [MAX_RW-1:0] r,
                                                 input logic              x,
                                                 input int                divisor);
    logic [STEP_W-1:0] t;
    logic [STEP_W-1:0] d;
    t = {r, x};
    d = STEP_W'(divisor);
    if (t >= d) t = t - d;
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_mod_step.sv
// ============================================================================
// serial_mod_step: combinational r_next = (2*r + x) mod DIVISOR for one bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_mod_step
  import serial_mod_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int RW      = $clog2(DIVISOR)
) (
  input  logic [RW-1:0] r_i,
  input  logic          x_i,
  output logic [RW-1:0] r_o
);

  logic [STEP_W-1:0] step_full;

  assign step_full = mod_step(MAX_RW'(r_i), x_i, DIVISOR);
  assign r_o       = RW'(step_full);

endmodule

`default_nettype wire

// File: rtl/serial_mod_checker.sv
// ============================================================================
// serial_mod_checker: running remainder of an MSB-first bit stream modulo
// DIVISOR, with optional fixed-length framing.  Revision: 1.0
// ============================================================================
`default_nettype none

module serial_mod_checker
  import serial_mod_pkg::*;
#(
  parameter int  DIVISOR   = 3,
  parameter int  FRAME_LEN = 64,
  localparam int RW        = $clog2(DIVISOR),
  localparam int CW        = (FRAME_LEN < 1) ? 1 : $clog2(FRAME_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x_i,
  input  logic          valid_i,
  input  logic          clear_i,
  output logic [RW-1:0] rem_o,
  output logic          div_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic [RW-1:0] frame_rem_o,
  output logic          frame_div_o
);

  localparam bit            FRAMED   = (FRAME_LEN > 0);
  localparam logic [CW-1:0] LAST_CNT = CW'((FRAME_LEN > 0) ? FRAME_LEN - 1 : 0);

  generate
    if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX ||
        FRAME_LEN < FRAME_LEN_MIN || FRAME_LEN > FRAME_LEN_MAX) begin : g_param_check
      $error("serial_mod_checker: DIVISOR or FRAME_LEN out of range");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [RW-1:0] frame_rem_q, frame_rem_d;
  logic          frame_done_q, frame_done_d;
  logic [RW-1:0] rem_next;

  serial_mod_step #(
    .DIVISOR(DIVISOR),
    .RW     (RW)
  ) u_step (
    .r_i(rem_q),
    .x_i(x_i),
    .r_o(rem_next)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    frame_rem_d  = frame_rem_q;
    frame_done_d = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      rem_d   = '0;
    end else if (valid_i) begin
      if (FRAMED && (cnt_q == LAST_CNT)) begin
        state_d      = IDLE;
        cnt_d        = '0;
        rem_d        = '0;
        frame_rem_d  = rem_next;
        frame_done_d = 1'b1;
      end else begin
        state_d = ACCUM;
        rem_d   = rem_next;
        if (FRAMED) cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      frame_rem_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      frame_rem_q  <= frame_rem_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rem_o        = rem_q;
  assign div_o        = (rem_q == '0);
  assign busy_o       = (state_q == ACCUM);
  assign frame_done_o = frame_done_q;
  assign frame_rem_o  = frame_rem_q;
  assign frame_div_o  = (frame_rem_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_serial_mod_checker.sv
// ============================================================================
// tb_serial_mod_checker: several parameterisations driven by a shared stream,
// each compared against an arithmetic model.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_mod_checker;

  localparam int NI = 6;

  function automatic int d_of(input int i);
    case (i)
      0: return 3;
      1: return 5;
      2: return 7;
      3: return 3;
      4: return 256;
      default: return 2;
    endcase
  endfunction

  function automatic int fl_of(input int i);
    case (i)
      0: return 0;
      1: return 4;
      2: return 8;
      3: return 8;
      4: return 16;
      default: return 1;
    endcase
  endfunction

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic x_i     = 1'b0;
  logic valid_i = 1'b0;
  logic clear_i = 1'b0;

  always #5 clk = ~clk;

  logic [8:0] a_rem  [NI];
  logic [8:0] a_frem [NI];
  logic       a_div  [NI];
  logic       a_busy [NI];
  logic       a_done [NI];
  logic       a_fdiv [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int DV  = d_of(gi);
      localparam int FV  = fl_of(gi);
      localparam int RWI = $clog2(DV);
      logic [RWI-1:0] rem, frem;
      logic           dv, bs, dn, fdv;
      serial_mod_checker #(.DIVISOR(DV), .FRAME_LEN(FV)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .x_i         (x_i),
        .valid_i     (valid_i),
        .clear_i     (clear_i),
        .rem_o       (rem),
        .div_o       (dv),
        .busy_o      (bs),
        .frame_done_o(dn),
        .frame_rem_o (frem),
        .frame_div_o (fdv)
      );
      assign a_rem[gi]  = 9'(rem);
      assign a_frem[gi] = 9'(frem);
      assign a_div[gi]  = dv;
      assign a_busy[gi] = bs;
      assign a_done[gi] = dn;
      assign a_fdiv[gi] = fdv;
    end
  endgenerate

  // Model: framed instances keep the whole frame value and reduce with %.
  longint m_val  [NI];
  int     m_cnt  [NI];
  longint m_fr   [NI];
  bit     m_busy [NI];
  bit     m_done [NI];
  int     n_frames4;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_val[i] = 0; m_cnt[i] = 0; m_fr[i] = 0; m_busy[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_step(input bit x, input bit v, input bit c);
    for (int i = 0; i < NI; i++) begin
      m_done[i] = 0;
      if (c) begin
        m_val[i] = 0; m_cnt[i] = 0; m_busy[i] = 0;
      end else if (v) begin
        if (fl_of(i) == 0) begin
          m_val[i]  = (m_val[i] * 2 + longint'(x)) % d_of(i);
          m_busy[i] = 1;
        end else begin
          m_val[i] = m_val[i] * 2 + longint'(x);
          m_cnt[i]++;
          if (m_cnt[i] == fl_of(i)) begin
            m_fr[i]   = m_val[i] % d_of(i);
            m_done[i] = 1;
            m_val[i]  = 0;
            m_cnt[i]  = 0;
            m_busy[i] = 0;
            if (i == 4) n_frames4++;
          end else begin
            m_busy[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    longint er;
    for (int i = 0; i < NI; i++) begin
      er = (fl_of(i) == 0) ? m_val[i] : (m_val[i] % d_of(i));
      check_value($sformatf("rem[%0d]", i),        64'(a_rem[i]),  64'(er));
      check_value($sformatf("div[%0d]", i),        64'(a_div[i]),  64'(er == 0));
      check_value($sformatf("div_vs_rem[%0d]", i), 64'(a_div[i]),  64'(a_rem[i] == 0));
      check_value($sformatf("busy[%0d]", i),       64'(a_busy[i]), 64'(m_busy[i]));
      check_value($sformatf("done[%0d]", i),       64'(a_done[i]), 64'(m_done[i]));
      check_value($sformatf("frem[%0d]", i),       64'(a_frem[i]), 64'(m_fr[i]));
      check_value($sformatf("fdiv[%0d]", i),       64'(a_fdiv[i]), 64'(m_fr[i] == 0));
    end
  endtask

  task automatic step(input bit x, input bit v, input bit c);
    x_i = x; valid_i = v; clear_i = c;
    @(posedge clk);
    model_step(x, v, c);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b0;
  endtask

  initial begin
    bit seq1 [8];
    int exp_rem0 [4];
    int exp_div0 [4];
    int cyc;
    bit rx, rv, rc;
    seq1     = '{1, 1, 0, 1, 1, 0, 1, 0};
    exp_rem0 = '{1, 0, 0, 1};
    exp_div0 = '{0, 1, 1, 0};
    n_frames4 = 0;
    model_reset();
    #12;
    check_all();
    check_value("reset_fdiv0", 64'(a_fdiv[0]), 64'd1);
    reset = 1'b0;

    // 13 then 10, MSB first
    for (int k = 0; k < 8; k++) begin
      step(seq1[k], 1'b1, 1'b0);
      if (k < 4) begin
        check_value("d3_rem_seq", 64'(a_rem[0]), 64'(exp_rem0[k]));
        check_value("d3_div_seq", 64'(a_div[0]), 64'(exp_div0[k]));
      end
      if (k == 3) begin
        check_value("d5_f1_done", 64'(a_done[1]), 64'd1);
        check_value("d5_f1_frem", 64'(a_frem[1]), 64'd3);
        check_value("d5_f1_fdiv", 64'(a_fdiv[1]), 64'd0);
      end
      if (k == 7) begin
        check_value("d5_f2_frem", 64'(a_frem[1]), 64'd0);
        check_value("d5_f2_fdiv", 64'(a_fdiv[1]), 64'd1);
        check_value("d5_f2_rem",  64'(a_rem[1]),  64'd0);
      end
    end

    // clear with valid after three bits of a new frame
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_value("clr_rem3",  64'(a_rem[3]),  64'd0);
    check_value("clr_busy3", 64'(a_busy[3]), 64'd0);
    check_value("clr_done3", 64'(a_done[3]), 64'd0);
    check_value("clr_frem3", 64'(a_frem[3]), 64'd2);
    step(1'b0, 1'b0, 1'b0);

    // 0xFF with valid on alternate cycles
    for (int k = 0; k < 16; k++) step(1'b1, (k % 2) == 0, 1'b0);
    check_value("d7_ff_frem", 64'(a_frem[2]), 64'd3);
    check_value("d7_ff_fdiv", 64'(a_fdiv[2]), 64'd0);

    // reset in the middle of a frame, then a full fresh frame of 0x80
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    async_reset();
    check_value("arst_busy2", 64'(a_busy[2]), 64'd0);
    for (int k = 0; k < 8; k++) step(k == 0, 1'b1, 1'b0);
    check_value("post_rst_done2", 64'(a_done[2]), 64'd1);
    check_value("post_rst_frem2", 64'(a_frem[2]), 64'd2);

    // random traffic until 64 complete DIVISOR=256 frames have been seen
    n_frames4 = 0;
    cyc = 0;
    while (n_frames4 < 64 && cyc < 20000) begin
      rx = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 7) != 0);
      rc = ($urandom_range(0, 199) == 0);
      step(rx, rv, rc);
      cyc++;
    end
    if (n_frames4 < 64) check_value("rand_frame_budget", 64'(n_frames4), 64'd64);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
